ta_cap_window: RTL and testbench



---
 rtl/ta_cap_window.sv | 230 +++++++++++++++++++++++
 tb/tb_ta_cap_window.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ta_cap_window.sv
// ---------------------------------------------------------------------------
// ta_cap_window
//
// Capture-window sequencer for the 250 MHz domain. A rising edge of the
// trigger stage's merge_en level (seen while idle) starts a window: the
// block waits cap_dly cycles, then writes the next cap_len qualified ADC
// samples into the capture RAM at addresses 0,1,2,... When the window
// closes it pulses cap_cmpt for one cycle, which ends merge_en upstream
// and re-arms the trigger. Dropping merge_en early aborts the window
// without cap_cmpt.
//
// Optional feature macro: CAP_TIMEOUT_EN
//   defined   : a stall of TO_CYC consecutive cycles without adc_valid while
//               capturing closes the window (cap_cmpt) and sets sticky cap_to.
//   undefined : no stall counter, cap_to tied low, capture waits forever.
//
// Ports
//   clk250    in   only clock
//   rst       in   asynchronous, active-high reset
//   merge_en  in   capture request level
//   cap_dly   in   delay before capture, latched at start
//   cap_len   in   samples per window (clamped to 2^AW), latched at start
//   adc_valid in   adc_data qualifier
//   adc_data  in   ADC sample
//   wr_en     out  RAM write strobe
//   wr_addr   out  RAM write address (sample index)
//   wr_data   out  RAM write data
//   cap_cmpt  out  one-cycle window-complete pulse
//   cap_busy  out  high while delaying or capturing
//   cap_to    out  sticky stall-timeout flag, cleared at the next start
// All outputs are registered.
// ---------------------------------------------------------------------------
module ta_cap_window #(
  parameter int DW     = 14,
  parameter int AW     = 10,
  parameter int DLYW   = 16,
  parameter int TO_CYC = 1024
) (
  input  logic            clk250,
  input  logic            rst,
  input  logic            merge_en,
  input  logic [DLYW-1:0] cap_dly,
  input  logic [AW:0]     cap_len,
  input  logic            adc_valid,
  input  logic [DW-1:0]   adc_data,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            cap_cmpt,
  output logic            cap_busy,
  output logic            cap_to
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]     MAX_LEN = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]     IDX_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [DLYW-1:0] DLY_ONE = {{(DLYW-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic            merge_prev_q, merge_prev_d;   // merge_en one cycle ago
  logic [DLYW-1:0] dly_cnt_q, dly_cnt_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     idx_q, idx_d;                 // next sample index
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            cmpt_q, cmpt_d;
  logic            busy_q, busy_d;

  logic            start;
  logic [AW:0]     len_clamped;
  logic [AW:0]     idx_inc;
  logic            last_accept;

`ifdef CAP_TIMEOUT_EN
  localparam int STALL_W = $clog2(TO_CYC + 1);
  logic [STALL_W-1:0] stall_q, stall_d;          // consecutive idle CAPT cycles
  logic               to_q, to_d;
`endif

  assign start       = merge_en && !merge_prev_q;
  assign len_clamped = (cap_len > MAX_LEN) ? MAX_LEN : cap_len;
  assign idx_inc     = idx_q + IDX_ONE;
  // idx never exceeds len-1 < 2^AW, so idx_inc cannot overflow and wr_addr
  // never wraps within a window.
  assign last_accept = adc_valid && (idx_inc == len_q);

  // NOTE: combinational next-state logic assigns every *_d a default first so
  // that no path through the case statement leaves a signal unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    merge_prev_d = merge_en;
    dly_cnt_d    = dly_cnt_q;
    len_d        = len_q;
    idx_d        = idx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cmpt_d       = 1'b0;
`ifdef CAP_TIMEOUT_EN
    stall_d      = stall_q;
    to_d         = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dly_cnt_d = cap_dly;
          len_d     = len_clamped;
          idx_d     = '0;
`ifdef CAP_TIMEOUT_EN
          stall_d   = '0;
          to_d      = 1'b0;
`endif
          state_d   = (cap_dly != '0) ? S_DELAY : S_CAPT;
        end
      end

      S_DELAY: begin
        // Entered with dly_cnt = D > 0; leaving when it reads 1 gives
        // exactly D cycles in this state.
        if (!merge_en) begin
          state_d = S_IDLE;
        end else if (dly_cnt_q == DLY_ONE) begin
          state_d = S_CAPT;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_ONE;
        end
      end

      S_CAPT: begin
        if (len_q == '0) begin
          // Empty window: complete without writing.
          state_d = S_DONE;
          cmpt_d  = 1'b1;
        end else if (last_accept) begin
          // Completion takes priority over a simultaneous merge_en drop.
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[AW-1:0];
          wr_data_d = adc_data;
          idx_d     = idx_inc;
          state_d   = S_DONE;
          cmpt_d    = 1'b1;
        end else if (!merge_en) begin
          state_d = S_IDLE;
        end else if (adc_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[AW-1:0];
          wr_data_d = adc_data;
          idx_d     = idx_inc;
`ifdef CAP_TIMEOUT_EN
          stall_d   = '0;
        end else if (stall_q == STALL_W'(TO_CYC - 1)) begin
          state_d = S_DONE;
          cmpt_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          stall_d = stall_q + STALL_W'(1);
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_DELAY) || (state_d == S_CAPT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      merge_prev_q <= 1'b0;
      dly_cnt_q    <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cmpt_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_prev_q <= merge_prev_d;
      dly_cnt_q    <= dly_cnt_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cmpt_q       <= cmpt_d;
      busy_q       <= busy_d;
    end
  end

`ifdef CAP_TIMEOUT_EN
  always_ff @(posedge clk250 or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      to_q    <= 1'b0;
    end else begin
      stall_q <= stall_d;
      to_q    <= to_d;
    end
  end

  assign cap_to = to_q;
`else
  assign cap_to = 1'b0;
`endif

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cap_cmpt = cmpt_q;
  assign cap_busy = busy_q;

endmodule

// File: tb/tb_ta_cap_window.sv
// ---------------------------------------------------------------------------
// tb_ta_cap_window
//
// Self-checking bench for ta_cap_window (DW=14, AW=10, DLYW=16, TO_CYC=16).
// Each table row holds the inputs driven during one cycle and the outputs
// expected right after the following clk250 edge. Long or asynchronous
// scenarios (length clamp, reset mid-window, stall timeout) are written out
// as sequences. Inputs change 1 ns after the rising edge, outputs are
// sampled at the same point.
// ---------------------------------------------------------------------------
module tb_ta_cap_window;

  logic        clk250;
  logic        rst;
  logic        merge_en;
  logic [15:0] cap_dly;
  logic [10:0] cap_len;
  logic        adc_valid;
  logic [13:0] adc_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [13:0] wr_data;
  logic        cap_cmpt;
  logic        cap_busy;
  logic        cap_to;

  ta_cap_window #(
    .DW    (14),
    .AW    (10),
    .DLYW  (16),
    .TO_CYC(16)
  ) dut (
    .clk250   (clk250),
    .rst      (rst),
    .merge_en (merge_en),
    .cap_dly  (cap_dly),
    .cap_len  (cap_len),
    .adc_valid(adc_valid),
    .adc_data (adc_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cap_cmpt (cap_cmpt),
    .cap_busy (cap_busy),
    .cap_to   (cap_to)
  );

  initial clk250 = 1'b0;
  always #5 clk250 = ~clk250;

  typedef struct {
    logic        me;
    logic [15:0] dly;
    logic [10:0] len;
    logic        v;
    logic [13:0] d;
    logic        e_en;
    logic [9:0]  e_addr;
    logic [13:0] e_data;
    logic        e_cmpt;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic me, input logic [15:0] dly, input logic [10:0] len,
                     input logic v, input logic [13:0] d, input logic e_en,
                     input logic [9:0] e_addr, input logic [13:0] e_data,
                     input logic e_cmpt, input logic e_busy);
    vec_t x;
    x.me = me; x.dly = dly; x.len = len; x.v = v; x.d = d;
    x.e_en = e_en; x.e_addr = e_addr; x.e_data = e_data;
    x.e_cmpt = e_cmpt; x.e_busy = e_busy;
    vecs.push_back(x);
  endtask

  // Row with merge_en low and nothing expected to happen.
  task automatic add_idle();
    add(1'b0, 16'd0, 11'd0, 1'b0, 14'h0, 1'b0, 10'd0, 14'h0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk250);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wr_en"},    32'(wr_en),    32'd0);
    check({tag, ".wr_addr"},  32'(wr_addr),  32'd0);
    check({tag, ".wr_data"},  32'(wr_data),  32'd0);
    check({tag, ".cap_cmpt"}, 32'(cap_cmpt), 32'd0);
    check({tag, ".cap_busy"}, 32'(cap_busy), 32'd0);
    check({tag, ".cap_to"},   32'(cap_to),   32'd0);
  endtask

  initial begin
    int n_wr;
    int cmpt_cyc;
    int cmpt_cnt;
    logic [9:0] last_addr;
    logic order_ok;

    rst = 1'b1; merge_en = 1'b0; cap_dly = '0; cap_len = '0;
    adc_valid = 1'b0; adc_data = '0;
    repeat (2) @(posedge clk250);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // ---------------- table ----------------
    add_idle();
    // Basic window: D=3, len=8, valid held high (also during the delay).
    add(1'b1, 16'd3, 11'd8, 1'b1, 14'h3fff, 1'b0, 10'd0, 14'h0, 1'b0, 1'b1);
    // cap_dly/cap_len change after start: must be ignored (latched).
    for (int k = 0; k < 3; k++)
      add(1'b1, 16'd0, 11'd0, 1'b1, 14'h3fff, 1'b0, 10'd0, 14'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      add(1'b1, 16'd0, 11'd0, 1'b1, 14'(16'h100 + i), 1'b1, 10'(i),
          14'(16'h100 + i), (i == 7), (i != 7));
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h3fff, 1'b0, 10'd0, 14'h0, 1'b0, 1'b0); // DONE
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h3fff, 1'b0, 10'd0, 14'h0, 1'b0, 1'b0); // held high: no restart
    add_idle();

    // Gapped valid 1,0,0,1,1,0,1; merge_en falls with the last sample.
    add(1'b1, 16'd0, 11'd4, 1'b0, 14'h0,   1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h200, 1'b1, 10'd0, 14'h200, 1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b0, 14'h201, 1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b0, 14'h202, 1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h203, 1'b1, 10'd1, 14'h203, 1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h204, 1'b1, 10'd2, 14'h204, 1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b0, 14'h205, 1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b0, 16'd0, 11'd0, 1'b1, 14'h206, 1'b1, 10'd3, 14'h206, 1'b1, 1'b0);
    // Rise during DONE is ignored, and merge_en staying high does not start.
    add(1'b1, 16'd0, 11'd4, 1'b1, 14'h0,   1'b0, 10'd0, 14'h0,   1'b0, 1'b0);
    add(1'b1, 16'd0, 11'd4, 1'b1, 14'h0,   1'b0, 10'd0, 14'h0,   1'b0, 1'b0);
    add_idle();

    // Empty window: cmpt one cycle after entering CAPT, no write.
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h5, 1'b0, 10'd0, 14'h0, 1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h5, 1'b0, 10'd0, 14'h0, 1'b1, 1'b0);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h5, 1'b0, 10'd0, 14'h0, 1'b0, 1'b0);
    add_idle();

    // Abort in CAPT after 2 of 8 samples.
    add(1'b1, 16'd1, 11'd8, 1'b1, 14'h3ff, 1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h3ff, 1'b0, 10'd0, 14'h0,   1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h300, 1'b1, 10'd0, 14'h300, 1'b0, 1'b1);
    add(1'b1, 16'd0, 11'd0, 1'b1, 14'h301, 1'b1, 10'd1, 14'h301, 1'b0, 1'b1);
    add(1'b0, 16'd0, 11'd0, 1'b1, 14'h302, 1'b0, 10'd0, 14'h0,   1'b0, 1'b0);
    add_idle();

    // Abort in DELAY.
    add(1'b1, 16'd5, 11'd2, 1'b1, 14'h0, 1'b0, 10'd0, 14'h0, 1'b0, 1'b1);
    add(1'b0, 16'd5, 11'd2, 1'b1, 14'h0, 1'b0, 10'd0, 14'h0, 1'b0, 1'b0);
    add_idle();

    foreach (vecs[i]) begin
      merge_en  = vecs[i].me;
      cap_dly   = vecs[i].dly;
      cap_len   = vecs[i].len;
      adc_valid = vecs[i].v;
      adc_data  = vecs[i].d;
      step();
      check($sformatf("v%0d.wr_en", i),    32'(wr_en),    32'(vecs[i].e_en));
      check($sformatf("v%0d.cap_cmpt", i), 32'(cap_cmpt), 32'(vecs[i].e_cmpt));
      check($sformatf("v%0d.cap_busy", i), 32'(cap_busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_en) begin
        check($sformatf("v%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
        check($sformatf("v%0d.wr_data", i), 32'(wr_data), 32'(vecs[i].e_data));
      end
    end

    // ---------------- length clamp: 2047 -> 1024 ----------------
    merge_en = 1'b0; adc_valid = 1'b0; step();
    merge_en = 1'b1; cap_dly = 16'd0; cap_len = 11'd2047; adc_valid = 1'b1;
    n_wr = 0; cmpt_cyc = -1; last_addr = '0; order_ok = 1'b1;
    for (int c = 0; c < 1030; c++) begin
      adc_data = 14'(c);
      step();
      if (wr_en) begin
        if (wr_addr != 10'(n_wr) || wr_data != 14'(c)) order_ok = 1'b0;
        n_wr++;
        last_addr = wr_addr;
      end
      if (cap_cmpt) cmpt_cyc = c;
    end
    check("clamp.writes",    32'(n_wr),      32'd1024);
    check("clamp.last_addr", 32'(last_addr), 32'd1023);
    check("clamp.order",     32'(order_ok),  32'd1);
    check("clamp.cmpt_cyc",  32'(cmpt_cyc),  32'd1024);
    merge_en = 1'b0; step();

    // ---------------- reset mid-CAPT ----------------
    merge_en = 1'b1; cap_dly = 16'd0; cap_len = 11'd8; adc_valid = 1'b1;
    adc_data = 14'h055;
    repeat (4) step();
    check("rst.pre_busy", 32'(cap_busy), 32'd1);
    check("rst.pre_wr",   32'(wr_en),    32'd1);
    #2 rst = 1'b1;
    merge_en = 1'b0;
    #1 check_all_zero("rst.async");
    repeat (2) begin
      step();
      check("rst.hold_wr",   32'(wr_en),    32'd0);
      check("rst.hold_cmpt", 32'(cap_cmpt), 32'd0);
    end
    rst = 1'b0;
    step();
    merge_en = 1'b1; adc_data = 14'h077;
    step();
    check("rst.restart_busy", 32'(cap_busy), 32'd1);
    step();
    check("rst.restart_wr",   32'(wr_en),   32'd1);
    check("rst.restart_addr", 32'(wr_addr), 32'd0);
    check("rst.restart_data", 32'(wr_data), 32'h077);
    merge_en = 1'b0; step();
    check("rst.abort_busy", 32'(cap_busy), 32'd0);

    // ---------------- stall: 3 samples then adc_valid low ----------------
    adc_valid = 1'b0; step();
    merge_en = 1'b1; cap_len = 11'd8; step();
    adc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adc_data = 14'(16'h11 + k);
      step();
    end
    check("stall.third_addr", 32'(wr_addr), 32'd2);
    adc_valid = 1'b0;
    cmpt_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (cap_cmpt) cmpt_cnt++;
    end
    check("stall.no_early_cmpt", 32'(cmpt_cnt), 32'd0);
    check("stall.busy_15",       32'(cap_busy), 32'd1);
    step();
`ifdef CAP_TIMEOUT_EN
    check("to.cmpt", 32'(cap_cmpt), 32'd1);
    check("to.flag", 32'(cap_to),   32'd1);
    check("to.busy", 32'(cap_busy), 32'd0);
    step();
    check("to.sticky", 32'(cap_to), 32'd1);
    merge_en = 1'b0; step();
    merge_en = 1'b1; step();
    check("to.cleared", 32'(cap_to),   32'd0);
    check("to.rearm",   32'(cap_busy), 32'd1);
`else
    check("nto.cmpt", 32'(cap_cmpt), 32'd0);
    check("nto.flag", 32'(cap_to),   32'd0);
    check("nto.busy", 32'(cap_busy), 32'd1);
    repeat (10) step();
    check("nto.still_busy", 32'(cap_busy), 32'd1);
    adc_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      adc_data = 14'(16'h20 + k);
      step();
    end
    check("nto.last_addr", 32'(wr_addr),  32'd7);
    check("nto.last_data", 32'(wr_data),  32'h24);
    check("nto.cmpt",      32'(cap_cmpt), 32'd1);
    check("nto.to_low",    32'(cap_to),   32'd0);
`endif
    merge_en = 1'b0; adc_valid = 1'b0; step();
    check("end.idle", 32'(cap_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
